decoder_3_8_burst: RTL and testbench

- Handshaked 3-to-8 decoder for streams of 3-bit codes.
- Each accepted beat is decoded to one-hot and OR-merged into a mask until the beat flagged last; the merged 8-bit mask is then presented as one output word.
- Sits downstream of the 8:3 encoder path and rebuilds the one-hot request vector from a serial code stream.
- Valid/ready on both sides; one burst result buffered.

---
 rtl/decoder_3_8_burst.sv | 174 +++++++++++++++++
 tb/tb_decoder_3_8_burst.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_3_8_burst.sv
// Handshaked 3-to-8 burst decoder: OR-merges one-hot decodes of a code stream into one
// buffered mask per burst. Optional macro DEC_PARITY_EN adds in_par / out_perr checking.
module decoder_3_8_burst #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_code,
   input  logic             in_en,
   input  logic             in_last,
`ifdef DEC_PARITY_EN
   input  logic             in_par,
   output logic             out_perr,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_y,
   output logic [CNT_W-1:0] out_beats,
   output logic             out_dup
);

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [7:0]       mask_q, mask_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             dup_q, dup_d;
   logic             out_valid_q, out_valid_d;
   logic [7:0]       out_y_q, out_y_d;
   logic [CNT_W-1:0] out_beats_q, out_beats_d;
   logic             out_dup_q, out_dup_d;

   logic             accept;
   logic [7:0]       onehot;
   logic [7:0]       base_mask;
   logic [CNT_W-1:0] base_count;
   logic             base_dup;
   logic [7:0]       merged_mask;
   logic [CNT_W-1:0] count_inc;
   logic             merged_dup;

`ifdef DEC_PARITY_EN
   logic perr_q, perr_d;
   logic out_perr_q, out_perr_d;
   logic base_perr;
   logic beat_perr;
   logic merged_perr;
`endif

   // Ready depends only on state and out_ready, never on in_valid.
   assign in_ready = (state_q == ST_ACC) || out_ready;
   assign accept   = in_valid && in_ready;

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      onehot = in_en ? (8'b1 << in_code) : 8'h00;

      // A beat accepted while a result is presented starts a fresh burst.
      if (state_q == ST_HOLD) begin
         base_mask  = 8'h00;
         base_count = '0;
         base_dup   = 1'b0;
      end else begin
         base_mask  = mask_q;
         base_count = count_q;
         base_dup   = dup_q;
      end

      merged_mask = base_mask | onehot;
      merged_dup  = base_dup | (|(base_mask & onehot));
      count_inc   = (base_count == CNT_MAX) ? base_count : base_count + CNT_ONE;
   end

`ifdef DEC_PARITY_EN
   always_comb begin
      base_perr   = (state_q == ST_HOLD) ? 1'b0 : perr_q;
      beat_perr   = in_par ^ (^{in_en, in_code});
      merged_perr = base_perr | beat_perr;
   end
`endif

   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      count_d     = count_q;
      dup_d       = dup_q;
      out_valid_d = out_valid_q;
      out_y_d     = out_y_q;
      out_beats_d = out_beats_q;
      out_dup_d   = out_dup_q;
`ifdef DEC_PARITY_EN
      perr_d      = perr_q;
      out_perr_d  = out_perr_q;
`endif

      if (state_q == ST_HOLD && out_ready) begin
         out_valid_d = 1'b0;
         state_d     = ST_ACC;
      end

      if (accept) begin
         if (in_last) begin
            out_y_d     = merged_mask;
            out_beats_d = count_inc;
            out_dup_d   = merged_dup;
            out_valid_d = 1'b1;
            state_d     = ST_HOLD;
            mask_d      = 8'h00;
            count_d     = '0;
            dup_d       = 1'b0;
`ifdef DEC_PARITY_EN
            out_perr_d  = merged_perr;
            perr_d      = 1'b0;
`endif
         end else begin
            mask_d  = merged_mask;
            count_d = count_inc;
            dup_d   = merged_dup;
            state_d = ST_ACC;
`ifdef DEC_PARITY_EN
            perr_d  = merged_perr;
`endif
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_ACC;
         mask_q      <= 8'h00;
         count_q     <= '0;
         dup_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_y_q     <= 8'h00;
         out_beats_q <= '0;
         out_dup_q   <= 1'b0;
`ifdef DEC_PARITY_EN
         perr_q      <= 1'b0;
         out_perr_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         count_q     <= count_d;
         dup_q       <= dup_d;
         out_valid_q <= out_valid_d;
         out_y_q     <= out_y_d;
         out_beats_q <= out_beats_d;
         out_dup_q   <= out_dup_d;
`ifdef DEC_PARITY_EN
         perr_q      <= perr_d;
         out_perr_q  <= out_perr_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_y     = out_y_q;
   assign out_beats = out_beats_q;
   assign out_dup   = out_dup_q;
`ifdef DEC_PARITY_EN
   assign out_perr  = out_perr_q;
`endif

endmodule

// File: tb/tb_decoder_3_8_burst.sv
// Directed self-checking bench for decoder_3_8_burst; a second instance with CNT_W=2
// shares the stimulus to exercise beat-count saturation.
module tb_decoder_3_8_burst;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [2:0] in_code;
   logic       in_en;
   logic       in_last;
   logic       in_par;
   logic       out_ready;

   logic       in_ready, out_valid, out_dup;
   logic [7:0] out_y;
   logic [3:0] out_beats;
   logic       in_ready_s, out_valid_s, out_dup_s;
   logic [7:0] out_y_s;
   logic [1:0] out_beats_s;
`ifdef DEC_PARITY_EN
   logic       out_perr, out_perr_s;
`endif

   int checks;
   int failures;

   decoder_3_8_burst #(.CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
      .in_en(in_en), .in_last(in_last),
`ifdef DEC_PARITY_EN
      .in_par(in_par), .out_perr(out_perr),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
      .out_beats(out_beats), .out_dup(out_dup)
   );

   decoder_3_8_burst #(.CNT_W(2)) dut_s (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready_s), .in_code(in_code),
      .in_en(in_en), .in_last(in_last),
`ifdef DEC_PARITY_EN
      .in_par(in_par), .out_perr(out_perr_s),
`endif
      .out_valid(out_valid_s), .out_ready(out_ready), .out_y(out_y_s),
      .out_beats(out_beats_s), .out_dup(out_dup_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   // Drives one beat from a falling edge and returns just after the rising edge that accepts it.
   task automatic send_beat(input logic [2:0] code, input logic en, input logic last,
                            input logic bad_par);
      int waits;
      waits = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_code  = code;
      in_en    = en;
      in_last  = last;
      in_par   = (^{en, code}) ^ bad_par;
      while (!in_ready && waits < 50) begin
         @(negedge clk);
         waits++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL beat_accept_timeout in_ready=%b required=1", in_ready);
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
   endtask

   task automatic test_reset;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      checks++; if (out_y !== 8'h00) begin failures++; $display("FAIL reset_y got=%h exp=00", out_y); end
      checks++; if (out_beats !== 4'd0) begin failures++; $display("FAIL reset_beats got=%0d exp=0", out_beats); end
      checks++; if (out_dup !== 1'b0) begin failures++; $display("FAIL reset_dup got=%b exp=0", out_dup); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
`ifdef DEC_PARITY_EN
      checks++; if (out_perr !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", out_perr); end
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single;
      send_beat(3'd5, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
      checks++; if (out_y !== 8'h20) begin failures++; $display("FAIL single_y got=%h exp=20", out_y); end
      checks++; if (out_beats !== 4'd1) begin failures++; $display("FAIL single_beats got=%0d exp=1", out_beats); end
      checks++; if (out_dup !== 1'b0) begin failures++; $display("FAIL single_dup got=%b exp=0", out_dup); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_consumed_valid got=%b exp=0", out_valid); end
      checks++; if (out_y !== 8'h20) begin failures++; $display("FAIL single_keep_y got=%h exp=20", out_y); end
   endtask

   task automatic test_burst;
      send_beat(3'd0, 1'b1, 1'b0, 1'b0);
      send_beat(3'd3, 1'b1, 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL burst_mid_valid got=%b exp=0", out_valid); end
      send_beat(3'd7, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL burst_valid got=%b exp=1", out_valid); end
      checks++; if (out_y !== 8'h89) begin failures++; $display("FAIL burst_y got=%h exp=89", out_y); end
      checks++; if (out_beats !== 4'd3) begin failures++; $display("FAIL burst_beats got=%0d exp=3", out_beats); end
      checks++; if (out_dup !== 1'b0) begin failures++; $display("FAIL burst_dup got=%b exp=0", out_dup); end
      idle(1);
   endtask

   task automatic test_dup;
      send_beat(3'd2, 1'b1, 1'b0, 1'b0);
      send_beat(3'd2, 1'b0, 1'b0, 1'b0);
      send_beat(3'd4, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_y !== 8'h14) begin failures++; $display("FAIL dis_y got=%h exp=14", out_y); end
      checks++; if (out_beats !== 4'd3) begin failures++; $display("FAIL dis_beats got=%0d exp=3", out_beats); end
      checks++; if (out_dup !== 1'b0) begin failures++; $display("FAIL dis_dup got=%b exp=0", out_dup); end
      send_beat(3'd1, 1'b1, 1'b0, 1'b0);
      send_beat(3'd1, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_y !== 8'h02) begin failures++; $display("FAIL dup_y got=%h exp=02", out_y); end
      checks++; if (out_beats !== 4'd2) begin failures++; $display("FAIL dup_beats got=%0d exp=2", out_beats); end
      checks++; if (out_dup !== 1'b1) begin failures++; $display("FAIL dup_flag got=%b exp=1", out_dup); end
      idle(1);
   endtask

   task automatic test_back_to_back;
      send_beat(3'd5, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      checks++; if (out_y !== 8'h20) begin failures++; $display("FAIL b2b_first_y got=%h exp=20", out_y); end
      in_valid = 1'b1; in_code = 3'd6; in_en = 1'b1; in_last = 1'b1; in_par = ^{1'b1, 3'd6};
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", out_valid); end
      checks++; if (out_y !== 8'h40) begin failures++; $display("FAIL b2b_y got=%h exp=40", out_y); end
      // Non-last beat taken while a result is presented opens a clean burst.
      in_code = 3'd3; in_last = 1'b0; in_par = ^{1'b1, 3'd3};
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_restart_valid got=%b exp=0", out_valid); end
      in_last = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_y !== 8'h08) begin failures++; $display("FAIL b2b_restart_y got=%h exp=08", out_y); end
      checks++; if (out_beats !== 4'd2) begin failures++; $display("FAIL b2b_restart_beats got=%0d exp=2", out_beats); end
      checks++; if (out_dup !== 1'b1) begin failures++; $display("FAIL b2b_restart_dup got=%b exp=1", out_dup); end
      idle(1);
   endtask

   task automatic test_hold;
      out_ready = 1'b0;
      send_beat(3'd3, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      in_valid = 1'b1; in_code = 3'd6; in_en = 1'b1; in_last = 1'b1; in_par = ^{1'b1, 3'd6};
      for (int i = 0; i < 5; i++) begin
         checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", i, out_valid); end
         checks++; if (out_y !== 8'h08 || out_beats !== 4'd1 || out_dup !== 1'b0) begin
            failures++; $display("FAIL hold_stable cyc=%0d got=%h/%0d/%b exp=08/1/0", i, out_y, out_beats, out_dup);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_release_ready got=%b exp=1", in_ready); end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL hold_next_valid got=%b exp=1", out_valid); end
      checks++; if (out_y !== 8'h40) begin failures++; $display("FAIL hold_next_y got=%h exp=40", out_y); end
      checks++; if (out_beats !== 4'd1) begin failures++; $display("FAIL hold_next_beats got=%0d exp=1", out_beats); end
      idle(1);
   endtask

   task automatic test_saturation;
      for (int i = 0; i < 6; i++) send_beat(3'd1, 1'b1, (i == 5), 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_beats_s !== 2'd3) begin failures++; $display("FAIL sat_beats got=%0d exp=3", out_beats_s); end
      checks++; if (out_y_s !== 8'h02) begin failures++; $display("FAIL sat_y got=%h exp=02", out_y_s); end
      checks++; if (out_dup_s !== 1'b1) begin failures++; $display("FAIL sat_dup got=%b exp=1", out_dup_s); end
      checks++; if (out_beats !== 4'd6) begin failures++; $display("FAIL wide_beats got=%0d exp=6", out_beats); end
      idle(1);
   endtask

   task automatic test_reset_mid;
      send_beat(3'd4, 1'b1, 1'b0, 1'b0);
      send_beat(3'd5, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
      @(negedge clk);
      rst = 1'b0;
      send_beat(3'd0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_y !== 8'h01) begin failures++; $display("FAIL rstmid_y got=%h exp=01", out_y); end
      checks++; if (out_beats !== 4'd1) begin failures++; $display("FAIL rstmid_beats got=%0d exp=1", out_beats); end
      idle(1);
      out_ready = 1'b0;
      send_beat(3'd2, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rsthold_pre_valid got=%b exp=1", out_valid); end
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rsthold_valid got=%b exp=0", out_valid); end
      checks++; if (out_y !== 8'h00) begin failures++; $display("FAIL rsthold_y got=%h exp=00", out_y); end
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      idle(1);
   endtask

`ifdef DEC_PARITY_EN
   task automatic test_parity;
      send_beat(3'd1, 1'b1, 1'b0, 1'b0);
      send_beat(3'd2, 1'b1, 1'b0, 1'b1);
      send_beat(3'd3, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_perr !== 1'b1) begin failures++; $display("FAIL perr_set got=%b exp=1", out_perr); end
      checks++; if (out_y !== 8'h0E) begin failures++; $display("FAIL perr_y got=%h exp=0e", out_y); end
      send_beat(3'd4, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_perr !== 1'b0) begin failures++; $display("FAIL perr_clear got=%b exp=0", out_perr); end
      idle(1);
   endtask
`endif

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_code   = 3'd0;
      in_en     = 1'b0;
      in_last   = 1'b0;
      in_par    = 1'b0;
      out_ready = 1'b1;
      #2 rst = 1'b1;
      test_reset;
      test_single;
      test_burst;
      test_dup;
      test_back_to_back;
      test_hold;
      test_saturation;
      test_reset_mid;
`ifdef DEC_PARITY_EN
      test_parity;
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
